mcu_seq_ctrl: RTL and testbench
===============================

// Module: mcu_seq_ctrl
// PURPOSE
//  Multi-cycle sequencer for the RISC-V MCU; companion to the combinational control decoder.
//  Steps each instruction through fetch/execute/memory/writeback, and owns the data-memory handshake.
//  Gates the decoder's RF_WE, memRDEN2 and memWE2 with per-state strobes.
//  Latches external interrupts and drives int_taken / pc_we for trap entry and mret.
// PARAMETERS
//  MEM_TIMEOUT  16  cycles a data-memory request may wait for mem_ack (used only with MCU_MEM_TIMEOUT_EN)
//  INTR_SYNC    2   synchronizer flops on intr (>=2)
// PORTS
//  clk        in   1  system clock, all state on rising edge
//  rst_n      in   1  asynchronous, active-low reset
//  opcode     in   7  ir[6:0]
//  func3      in   3  ir[14:12]
//  intr       in   1  external interrupt, level, asynchronous to clk
//  csr_mie    in   1  mstatus.MIE from CSR file
//  mem_ack    in   1  data memory completed current load/store request
//  pc_we      out  1  PC register load strobe
//  memRDEN1   out  1  instruction memory read enable
//  memRDEN2   out  1  data memory read request (held until ack)
//  memWE2     out  1  data memory write request (held until ack)
//  rf_we      out  1  register-file write strobe (ANDed with decoder RF_WE upstream)
//  csr_we     out  1  CSR write strobe (CSRRW/CSRRS/CSRRC)
//  int_taken  out  1  one-cycle trap entry: PC<-mtvec, mepc<-PC, MIE cleared by CSR file
//  mret_exec  out  1  one-cycle mret: PC<-mepc, MIE restored
//  bus_err    out  1  one-cycle data-memory timeout flag (MCU_MEM_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  States: FETCH, EXEC, MEM, WB, INTR.
//  Reset (async, rst_n=0): state=FETCH; all outputs 0; intr pending, sync flops and timeout counter cleared.
//  Reset mid-MEM aborts the request immediately; no write completes.
//  FETCH: memRDEN1=1; next state EXEC.
//  EXEC, by opcode:
//   LOAD: memRDEN2=1.
//    mem_ack=1: next state WB.
//    mem_ack=0: next state MEM.
//   STORE: memWE2=1.
//    mem_ack=1: pc_we=1; instruction completes.
//    mem_ack=0: next state MEM.
//   SYS func3=000 (mret): mret_exec=1, pc_we=1.
//   SYS func3 in {001,010,011}: csr_we=1, rf_we=1, pc_we=1.
//   BRANCH: pc_we=1; rf_we=0.
//   LUI, AUIPC, JAL, JALR, OP_IMM, OP_RG3: rf_we=1, pc_we=1.
//   Any other opcode: NOP, pc_we=1, no other strobes.
//  MEM: hold memRDEN2 or memWE2 every cycle until mem_ack.
//   Load ack: next state WB.
//   Store ack: pc_we=1 in the ack cycle; instruction completes.
//  WB: rf_we=1, pc_we=1; instruction completes.
//  Completion (pc_we asserted outside INTR):
//   pending && csr_mie (sampled that cycle): next state INTR.
//   Otherwise: next state FETCH.
//  INTR: int_taken=1, pc_we=1; pending cleared; next state FETCH.
//  Interrupt latch: intr passes INTR_SYNC flops; a rising edge of the synced signal sets pending.
//   Pending is sticky until INTR is entered.
//   A new edge in the same cycle as the clear keeps pending set.
//  Latencies:
//   ALU/branch/jump: 2 cycles.
//   Store: >=2 cycles.
//   Load: >=3 cycles.
//   Trap entry: +1 cycle after completion.
//  Interrupts never preempt an in-flight MEM.
//  mret with pending && csr_mie: mret completes, then INTR on the next cycle.
//  Only one of int_taken, mret_exec, bus_err may be high in any cycle.
// CONFIGURATION
//  `define MCU_MEM_TIMEOUT_EN present:
//   An 8-bit counter runs in MEM.
//   On reaching MEM_TIMEOUT-1 without ack: drop the request; bus_err=1, pc_we=1, rf_we=0; then interrupt check.
//   The counter clears on entering MEM.
//  MCU_MEM_TIMEOUT_EN absent: no counter; MEM waits indefinitely; bus_err tied 0.
// STRUCTURE
//  Package mcu_pkg: opcode_t, func3s_t (MRET/CSRRW/CSRRS/CSRRC), seq_state_t.
//  Sub-module mcu_intr_latch: synchronizer, edge detect and sticky pending (inputs clr; output pending).
// TESTING
//  ADDI at reset release -> FETCH,EXEC; rf_we=1 and pc_we=1 in cycle 2; then FETCH.
//  LOAD with mem_ack 3 cycles after EXEC -> memRDEN2 high 4 cycles; then WB with rf_we=1, pc_we=1.
//  STORE with mem_ack in EXEC -> memWE2 and pc_we high the same cycle; rf_we=0.
//  intr pulse during load MEM, csr_mie=1 -> no int_taken until after WB; int_taken 1 cycle; then FETCH.
//  Same pulse with csr_mie=0, then mret (func3=000) -> mret_exec=1; INTR stays blocked until csr_mie=1.
//  rst_n low mid-MEM store -> memWE2 drops asynchronously; FETCH after release; with MCU_MEM_TIMEOUT_EN, no ack 16 cycles -> bus_err=1.

Source files
------------

// File: rtl/mcu_pkg.sv
// Shared types for the MCU multi-cycle sequencer: opcodes, system func3
// codes, sequencer states and the packed strobe bundle.
package mcu_pkg;

  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_IMM    = 7'b0010011,
    OP_RG3    = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_SYS    = 7'b1110011
  } opcode_t;

  typedef enum logic [2:0] {
    F3_MRET  = 3'b000,
    F3_CSRRW = 3'b001,
    F3_CSRRS = 3'b010,
    F3_CSRRC = 3'b011
  } func3s_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_WB,
    S_INTR
  } seq_state_t;

  // All sequencer strobes in one bundle so they can be defaulted and gated together.
  typedef struct packed {
    logic pc_we;
    logic rd1;
    logic rd2;
    logic we2;
    logic rf_we;
    logic csr_we;
    logic int_taken;
    logic mret_exec;
    logic bus_err;
  } seq_out_t;

  // Opcodes that write a result straight from the ALU/jump path in EXEC.
  function automatic logic is_rf_op(input logic [6:0] op);
    return (op == OP_LUI) || (op == OP_AUIPC) || (op == OP_JAL) ||
           (op == OP_JALR) || (op == OP_IMM) || (op == OP_RG3);
  endfunction

endpackage

// File: rtl/mcu_intr_latch.sv
// External interrupt capture: INTR_SYNC-stage synchronizer, rising-edge
// detect on the synced level, and a sticky pending flag cleared by clr.
module mcu_intr_latch
  import mcu_pkg::*;
#(
  parameter int INTR_SYNC = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic intr,
  input  logic clr,
  output logic pending
);

  logic [INTR_SYNC-1:0] sync_q;
  logic                 sync_d;
  logic                 rise;

  assign rise = sync_q[INTR_SYNC-1] & ~sync_d;

  // Synchronize, remember last synced level, and hold pending until cleared;
  // an edge arriving with the clear wins so it is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q  <= '0;
      sync_d  <= 1'b0;
      pending <= 1'b0;
    end else begin
      sync_q  <= {sync_q[INTR_SYNC-2:0], intr};
      sync_d  <= sync_q[INTR_SYNC-1];
      pending <= rise | (pending & ~clr);
    end
  end

endmodule

// File: rtl/mcu_seq_ctrl.sv
// Multi-cycle sequencer for the RISC-V MCU: FETCH/EXEC/MEM/WB/INTR.
// Strobes are decoded from state plus the same-cycle mem_ack, so a memory
// op acked in its first cycle completes without an extra state.
// Optional feature: define MCU_MEM_TIMEOUT_EN to abort data-memory requests
// that wait MEM_TIMEOUT cycles in MEM, flagging bus_err.
module mcu_seq_ctrl
  import mcu_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int INTR_SYNC   = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] opcode,
  input  logic [2:0] func3,
  input  logic       intr,
  input  logic       csr_mie,
  input  logic       mem_ack,
  output logic       pc_we,
  output logic       memRDEN1,
  output logic       memRDEN2,
  output logic       memWE2,
  output logic       rf_we,
  output logic       csr_we,
  output logic       int_taken,
  output logic       mret_exec,
  output logic       bus_err
);

  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  seq_state_t state;
  seq_out_t   o;
  seq_out_t   og;
  logic       is_ld_q;
  logic       pending;
  logic       clr;
  logic       trap;
  logic       tmo;

  assign clr  = (state == S_INTR);
  assign trap = pending & csr_mie;

  mcu_intr_latch #(.INTR_SYNC(INTR_SYNC)) u_intr (
    .clk     (clk),
    .rst_n   (rst_n),
    .intr    (intr),
    .clr     (clr),
    .pending (pending)
  );

`ifdef MCU_MEM_TIMEOUT_EN
  logic [7:0] tmo_cnt;

  // Count unacked MEM cycles; restarts from zero every time MEM is entered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                      tmo_cnt <= '0;
    else if (state != S_MEM)         tmo_cnt <= '0;
    else if (!mem_ack)               tmo_cnt <= tmo_cnt + 8'd1;
  end

  assign tmo = (state == S_MEM) && !mem_ack && (tmo_cnt == TMO_LAST);
`else
  logic unused_cfg;
  assign unused_cfg = ^TMO_LAST;
  assign tmo        = 1'b0;
`endif

  // Strobe decode from current state, instruction fields and mem_ack.
  always_comb begin
    o = '0;
    case (state)
      S_FETCH: o.rd1 = 1'b1;
      S_EXEC: begin
        if (opcode == OP_LOAD) begin
          o.rd2 = 1'b1;
        end else if (opcode == OP_STORE) begin
          o.we2   = 1'b1;
          o.pc_we = mem_ack;
        end else if (opcode == OP_SYS) begin
          o.pc_we = 1'b1;
          case (func3)
            F3_MRET:                      o.mret_exec = 1'b1;
            F3_CSRRW, F3_CSRRS, F3_CSRRC: begin
              o.csr_we = 1'b1;
              o.rf_we  = 1'b1;
            end
            default: ;
          endcase
        end else begin
          o.pc_we = 1'b1;
          o.rf_we = is_rf_op(opcode);
        end
      end
      S_MEM: begin
        if (tmo) begin
          o.bus_err = 1'b1;
          o.pc_we   = 1'b1;
        end else if (is_ld_q) begin
          o.rd2 = 1'b1;
        end else begin
          o.we2   = 1'b1;
          o.pc_we = mem_ack;
        end
      end
      S_WB: begin
        o.rf_we = 1'b1;
        o.pc_we = 1'b1;
      end
      S_INTR: begin
        o.int_taken = 1'b1;
        o.pc_we     = 1'b1;
      end
      default: ;
    endcase
  end

  // Reset forces every strobe low immediately, aborting any held request.
  assign og        = rst_n ? o : '0;
  assign pc_we     = og.pc_we;
  assign memRDEN1  = og.rd1;
  assign memRDEN2  = og.rd2;
  assign memWE2    = og.we2;
  assign rf_we     = og.rf_we;
  assign csr_we    = og.csr_we;
  assign int_taken = og.int_taken;
  assign mret_exec = og.mret_exec;
  assign bus_err   = og.bus_err;

  // Sequencer state; any completion checks for a takeable interrupt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      is_ld_q <= 1'b0;
    end else begin
      case (state)
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          is_ld_q <= (opcode == OP_LOAD);
          if (opcode == OP_LOAD)                   state <= mem_ack ? S_WB : S_MEM;
          else if (opcode == OP_STORE && !mem_ack) state <= S_MEM;
          else                                     state <= trap ? S_INTR : S_FETCH;
        end
        S_MEM: begin
          if (tmo)                     state <= trap ? S_INTR : S_FETCH;
          else if (is_ld_q && mem_ack) state <= S_WB;
          else if (mem_ack)            state <= trap ? S_INTR : S_FETCH;
        end
        S_WB:    state <= trap ? S_INTR : S_FETCH;
        S_INTR:  state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_mcu_seq_ctrl.sv
// Directed scoreboard bench for mcu_seq_ctrl. Each stimulus cycle pushes
// the hand-derived strobe vector; a monitor pops on every cycle in which the
// DUT drives any strobe. Vector order:
// {pc_we,memRDEN1,memRDEN2,memWE2,rf_we,csr_we,int_taken,mret_exec,bus_err}
module tb_mcu_seq_ctrl;

  localparam logic [6:0] LD   = 7'b0000011;
  localparam logic [6:0] ST   = 7'b0100011;
  localparam logic [6:0] BR   = 7'b1100011;
  localparam logic [6:0] ADDI = 7'b0010011;
  localparam logic [6:0] SYS  = 7'b1110011;
  localparam logic [6:0] FNC  = 7'b0001111;

  localparam logic [8:0] E_F    = 9'b010000000;
  localparam logic [8:0] E_ALU  = 9'b100010000;
  localparam logic [8:0] E_LD   = 9'b001000000;
  localparam logic [8:0] E_WB   = 9'b100010000;
  localparam logic [8:0] E_STA  = 9'b100100000;
  localparam logic [8:0] E_STW  = 9'b000100000;
  localparam logic [8:0] E_PC   = 9'b100000000;
  localparam logic [8:0] E_MRET = 9'b100000010;
  localparam logic [8:0] E_CSR  = 9'b100011000;
  localparam logic [8:0] E_INT  = 9'b100000100;
  localparam logic [8:0] E_BERR = 9'b100000001;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [6:0] opcode = '0;
  logic [2:0] func3 = '0;
  logic       intr = 1'b0, csr_mie = 1'b1, mem_ack = 1'b0;
  logic       pc_we, memRDEN1, memRDEN2, memWE2, rf_we, csr_we;
  logic       int_taken, mret_exec, bus_err;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  logic [8:0] expq[$];
  logic [8:0] outv;

  assign outv = {pc_we, memRDEN1, memRDEN2, memWE2, rf_we, csr_we,
                 int_taken, mret_exec, bus_err};

  mcu_seq_ctrl #(.MEM_TIMEOUT(16), .INTR_SYNC(2)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .func3(func3), .intr(intr),
    .csr_mie(csr_mie), .mem_ack(mem_ack), .pc_we(pc_we), .memRDEN1(memRDEN1),
    .memRDEN2(memRDEN2), .memWE2(memWE2), .rf_we(rf_we), .csr_we(csr_we),
    .int_taken(int_taken), .mret_exec(mret_exec), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [8:0] act, input logic [8:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%b want=%b", nm, act, exp);
    end
  endtask

  // One sequencer cycle: drive inputs, queue the expected strobes, advance.
  task automatic step(input logic [6:0] op, input logic [2:0] f3, input logic ir,
                      input logic mie, input logic ack, input logic [8:0] e);
    opcode  = op;
    func3   = f3;
    intr    = ir;
    csr_mie = mie;
    mem_ack = ack;
    expq.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // Monitor: any strobe activity is a DUT output event to score.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && outv !== 9'b0) begin
        if (expq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out got=%b want=none", outv);
        end else begin
          chk($sformatf("cycle%0d", cyc), outv, expq.pop_front());
        end
        cyc++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("reset_outs", outv, 9'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    // ADDI straight out of reset
    step(ADDI, 3'b000, 0, 1, 0, E_F);
    step(ADDI, 3'b000, 0, 1, 0, E_ALU);
    // LOAD acked 3 cycles after EXEC
    step(LD, 3'b010, 0, 1, 0, E_F);
    step(LD, 3'b010, 0, 1, 0, E_LD);
    step(LD, 3'b010, 0, 1, 0, E_LD);
    step(LD, 3'b010, 0, 1, 0, E_LD);
    step(LD, 3'b010, 0, 1, 1, E_LD);
    step(LD, 3'b010, 0, 1, 0, E_WB);
    // STORE acked in EXEC
    step(ST, 3'b010, 0, 1, 0, E_F);
    step(ST, 3'b010, 0, 1, 1, E_STA);
    // intr during load MEM, MIE=1: trap only after WB
    step(LD, 3'b010, 0, 1, 0, E_F);
    step(LD, 3'b010, 0, 1, 0, E_LD);
    step(LD, 3'b010, 1, 1, 0, E_LD);
    step(LD, 3'b010, 1, 1, 0, E_LD);
    step(LD, 3'b010, 1, 1, 0, E_LD);
    step(LD, 3'b010, 0, 1, 1, E_LD);
    step(LD, 3'b010, 0, 1, 0, E_WB);
    step(ADDI, 3'b000, 0, 1, 0, E_INT);
    // intr with MIE=0: stays pending through ADDI and mret
    step(ADDI, 3'b000, 1, 0, 0, E_F);
    step(ADDI, 3'b000, 1, 0, 0, E_ALU);
    step(ADDI, 3'b000, 1, 0, 0, E_F);
    step(ADDI, 3'b000, 0, 0, 0, E_ALU);
    step(SYS, 3'b000, 0, 0, 0, E_F);
    step(SYS, 3'b000, 0, 0, 0, E_MRET);
    step(ADDI, 3'b000, 0, 1, 0, E_F);
    step(ADDI, 3'b000, 0, 1, 0, E_ALU);
    step(ADDI, 3'b000, 0, 1, 0, E_INT);
    // new intr; branch and CSRRW with MIE=0, then mret with MIE=1 traps
    step(BR, 3'b000, 1, 0, 0, E_F);
    step(BR, 3'b000, 1, 0, 0, E_PC);
    step(SYS, 3'b001, 1, 0, 0, E_F);
    step(SYS, 3'b001, 0, 0, 0, E_CSR);
    step(SYS, 3'b000, 0, 1, 0, E_F);
    step(SYS, 3'b000, 0, 1, 0, E_MRET);
    step(FNC, 3'b000, 0, 1, 0, E_INT);
    // unknown opcode and unsupported SYS func3 behave as NOPs
    step(FNC, 3'b000, 0, 1, 0, E_F);
    step(FNC, 3'b000, 0, 1, 0, E_PC);
    step(SYS, 3'b100, 0, 1, 0, E_F);
    step(SYS, 3'b100, 0, 1, 0, E_PC);
    // STORE waiting in MEM, acked on second MEM cycle
    step(ST, 3'b010, 0, 1, 0, E_F);
    step(ST, 3'b010, 0, 1, 0, E_STW);
    step(ST, 3'b010, 0, 1, 0, E_STW);
    step(ST, 3'b010, 0, 1, 1, E_STA);
    // reset asserted mid-MEM store
    step(ST, 3'b010, 0, 1, 0, E_F);
    step(ST, 3'b010, 0, 1, 0, E_STW);
    step(ST, 3'b010, 0, 1, 0, E_STW);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_mem_we2", {8'b0, memWE2}, 9'b0);
    chk("rst_mid_mem_all", outv, 9'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(ADDI, 3'b000, 0, 1, 0, E_F);
    step(ADDI, 3'b000, 0, 1, 0, E_ALU);
`ifdef MCU_MEM_TIMEOUT_EN
    // load never acked: 16th MEM cycle drops the request and flags bus_err
    step(LD, 3'b010, 0, 1, 0, E_F);
    step(LD, 3'b010, 0, 1, 0, E_LD);
    for (int i = 0; i < 15; i++) step(LD, 3'b010, 0, 1, 0, E_LD);
    step(LD, 3'b010, 0, 1, 0, E_BERR);
    step(ADDI, 3'b000, 0, 1, 0, E_F);
    step(ADDI, 3'b000, 0, 1, 0, E_ALU);
`endif
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("queue_drained", 9'(expq.size()), 9'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
